// File: rtl/dm_resp.sv
// Data memory with byte-lane writes, sticky out-of-range flag and optional write log.
// Define DM_RESP_LOG_EN to build the write-log FIFO; otherwise log outputs are tied 0.
module dm_resp #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LOG_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_wdata,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        err_oor,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [3:0]  log_byteen,
    output logic [31:0] log_wdata,
    output logic        log_ovf,
    output logic [7:0]  log_drops
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          r_oor;
    logic [29:0]   w_idx;
    logic [AW-1:0] w_widx;
    logic          w_inrange;
    logic          w_wr;
    logic [31:0]   w_rword;
    logic          w_unused_lsb;

    assign w_idx        = m_data_addr[31:2];
    assign w_widx       = w_idx[AW-1:0];
    assign w_inrange    = ({2'b00, w_idx} < 32'(DEPTH_WORDS));
    assign w_wr         = w_inrange && (m_data_byteen != 4'b0000);
    assign w_rword      = r_mem[w_widx];
    assign w_unused_lsb = ^m_data_addr[1:0];

    // Read port shows pre-write contents; the write lands on the edge.
    assign m_data_rdata = (reset || !w_inrange) ? 32'h0 : w_rword;
    assign err_oor      = r_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_wr) begin
            for (int l = 0; l < 4; l++) begin
                if (m_data_byteen[l]) begin
                    r_mem[w_widx][8*l +: 8] <= m_data_wdata[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oor <= 1'b0;
        end else if (!w_inrange) begin
            r_oor <= 1'b1;
        end
    end

`ifdef DM_RESP_LOG_EN
    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    logic [31:0]   r_lpc   [LOG_DEPTH];
    logic [31:0]   r_laddr [LOG_DEPTH];
    logic [3:0]    r_lbe   [LOG_DEPTH];
    logic [31:0]   r_lwd   [LOG_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_cnt;
    logic          r_ovf;
    logic [7:0]    r_drops;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_show;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (PW+1)'(LOG_DEPTH));
    assign w_pop   = !w_empty && log_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign w_push  = w_wr && (!w_full || w_pop);
    assign w_drop  = w_wr && w_full && !w_pop;
    assign w_show  = !reset && !w_empty;

    assign log_valid  = w_show;
    assign log_pc     = w_show ? r_lpc[r_rptr]   : 32'h0;
    assign log_addr   = w_show ? r_laddr[r_rptr] : 32'h0;
    assign log_byteen = w_show ? r_lbe[r_rptr]   : 4'h0;
    assign log_wdata  = w_show ? r_lwd[r_rptr]   : 32'h0;
    assign log_ovf    = r_ovf;
    assign log_drops  = r_drops;

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_lpc[r_wptr]   <= m_inst_addr;
            r_laddr[r_wptr] <= {w_idx, 2'b00};
            r_lbe[r_wptr]   <= m_data_byteen;
            r_lwd[r_wptr]   <= m_data_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_drops <= 8'h0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drops != 8'hFF) begin
                    r_drops <= r_drops + 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_log;

    assign w_unused_log = ^{log_ready, m_inst_addr};
    assign log_valid    = 1'b0;
    assign log_pc       = 32'h0;
    assign log_addr     = 32'h0;
    assign log_byteen   = 4'h0;
    assign log_wdata    = 32'h0;
    assign log_ovf      = 1'b0;
    assign log_drops    = 8'h0;
`endif

endmodule

// File: tb/tb_dm_resp.sv
// Directed plus randomized bench for dm_resp against a word-array and queue model.
module tb_dm_resp;

`ifdef DM_RESP_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif
    localparam int DW = 3072;
    localparam int LD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m_data_addr = 32'h0;
    logic [3:0]  m_data_byteen = 4'h0;
    logic [31:0] m_data_wdata = 32'h0;
    logic [31:0] m_inst_addr = 32'h0;
    logic [31:0] m_data_rdata;
    logic        err_oor;
    logic        log_valid;
    logic        log_ready = 1'b0;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [3:0]  log_byteen;
    logic [31:0] log_wdata;
    logic        log_ovf;
    logic [7:0]  log_drops;

    dm_resp dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_byteen (m_data_byteen),
        .m_data_wdata  (m_data_wdata),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .err_oor       (err_oor),
        .log_valid     (log_valid),
        .log_ready     (log_ready),
        .log_pc        (log_pc),
        .log_addr      (log_addr),
        .log_byteen    (log_byteen),
        .log_wdata     (log_wdata),
        .log_ovf       (log_ovf),
        .log_drops     (log_drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } ent_t;

    logic [31:0] mm [DW];
    ent_t        q[$];
    bit          m_oor;
    bit          m_ovf;
    int          m_drops;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        return (a < 32'(4*DW)) ? mm[idx] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DW; i++) mm[i] = 32'h0;
        q.delete();
        m_oor = 0;
        m_ovf = 0;
        m_drops = 0;
    endtask

    // Apply one cycle of access, check pre-edge outputs, then advance the model.
    task automatic step(input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] pc,
                        input bit rdy, output logic [31:0] rd,
                        output logic [31:0] hpc);
        bit   inr;
        bit   pop;
        ent_t e;
        @(negedge clk);
        m_data_addr = a;
        m_data_byteen = be;
        m_data_wdata = wd;
        m_inst_addr = pc;
        log_ready = rdy;
        #1;
        rd = m_data_rdata;
        hpc = log_pc;
        chk("rdata", m_data_rdata, mread(a));
        chk("err_oor", {31'b0, err_oor}, {31'b0, m_oor});
        chk("log_valid", {31'b0, log_valid}, {31'b0, q.size() > 0});
        chk("log_pc", log_pc, q.size() > 0 ? q[0].pc : 32'h0);
        chk("log_addr", log_addr, q.size() > 0 ? q[0].addr : 32'h0);
        chk("log_byteen", {28'b0, log_byteen}, {28'b0, q.size() > 0 ? q[0].be : 4'h0});
        chk("log_wdata", log_wdata, q.size() > 0 ? q[0].wd : 32'h0);
        chk("log_ovf", {31'b0, log_ovf}, {31'b0, m_ovf});
        chk("log_drops", {24'b0, log_drops}, 32'(m_drops));
        @(posedge clk);
        inr = (a < 32'(4*DW));
        if (!inr) m_oor = 1;
        if (inr && be != 4'h0) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mm[a >> 2][8*l +: 8] = wd[8*l +: 8];
        end
        if (LOG) begin
            pop = (q.size() > 0) && rdy;
            if (pop) void'(q.pop_front());
            if (inr && be != 4'h0) begin
                if (q.size() < LD) begin
                    e.pc = pc;
                    e.addr = {a[31:2], 2'b00};
                    e.be = be;
                    e.wd = wd;
                    q.push_back(e);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_data_addr = 32'h20;
        m_data_byteen = 4'hF;
        m_data_wdata = 32'h1234_5678;
        log_ready = 1'b0;
        #1;
        chk("rst_rdata", m_data_rdata, 32'h0);
        chk("rst_valid", {31'b0, log_valid}, 32'h0);
        chk("rst_pc", log_pc, 32'h0);
        @(negedge clk);
        chk("rst_oor", {31'b0, err_oor}, 32'h0);
        m_data_byteen = 4'h0;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] hpc;
        logic [31:0] a;
        int          vcnt;
        model_clear();
        do_reset();
        step(32'h20, 4'h0, 32'h0, 32'h0, 1'b0, rd, hpc);
        chk("rst_write_ignored", rd, 32'h0);

        step(32'h10, 4'hF, 32'hDEAD_BEEF, 32'h100, 1'b0, rd, hpc);
        chk("req030_pre", rd, 32'h0);
        step(32'h10, 4'h0, 32'h0, 32'h0, 1'b0, rd, hpc);
        chk("req030_read", rd, 32'hDEAD_BEEF);
        step(32'h12, 4'b0100, 32'h00AA_0000, 32'h104, 1'b0, rd, hpc);
        step(32'h10, 4'h0, 32'h0, 32'h0, 1'b0, rd, hpc);
        chk("req031_read", rd, 32'hDEAA_BEEF);
        step(32'h3000, 4'hF, 32'hFFFF_FFFF, 32'h108, 1'b0, rd, hpc);
        chk("req032_rdata", rd, 32'h0);
        step(32'h0, 4'h0, 32'h0, 32'h0, 1'b0, rd, hpc);
        chk("req032_word0", rd, 32'h0);
        chk("req032_oor", {31'b0, err_oor}, 32'h1);
        chk("req032_nolog", {31'b0, log_valid}, {31'b0, LOG});

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0)
                a = 32'(4*DW) + ($urandom & 32'h0000_FFFF);
            else
                a = $urandom_range(0, 4*DW - 1);
            if ($urandom_range(0, 7) == 0) a = a & 32'h3C;
            step(a, 4'($urandom), $urandom, $urandom, 1'($urandom), rd, hpc);
        end

        do_reset();
        for (int k = 0; k < 10; k++)
            step(32'h200 + 32'(4*k), 4'hF, 32'hA000_0000 + 32'(k),
                 32'h3000 + 32'(4*k), 1'b0, rd, hpc);
        step(32'h0, 4'h0, 32'h0, 32'h0, 1'b0, rd, hpc);
        chk("req033_ovf", {31'b0, log_ovf}, {31'b0, LOG});
        chk("req033_drops", {24'b0, log_drops}, LOG ? 32'd2 : 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(32'h0, 4'h0, 32'h0, 32'h0, 1'b1, rd, hpc);
            chk("req033_order", hpc, LOG ? 32'h3000 + 32'(4*k) : 32'h0);
        end
        step(32'h0, 4'h0, 32'h0, 32'h0, 1'b1, rd, hpc);
        chk("req033_empty", {31'b0, log_valid}, 32'h0);

        do_reset();
        step(32'h10, 4'hF, 32'h5555_AAAA, 32'h4000, 1'b0, rd, hpc);
        for (int k = 1; k < 8; k++)
            step(32'h40 + 32'(4*k), 4'h3, $urandom, 32'h4000 + 32'(4*k),
                 1'b0, rd, hpc);
        step(32'h80, 4'hF, 32'h7777_7777, 32'h4100, 1'b1, rd, hpc);
        step(32'h0, 4'h0, 32'h0, 32'h0, 1'b0, rd, hpc);
        chk("req034_drops", {24'b0, log_drops}, 32'h0);
        chk("req034_ovf", {31'b0, log_ovf}, 32'h0);
        vcnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(32'h0, 4'h0, 32'h0, 32'h0, 1'b1, rd, hpc);
            if (log_valid) vcnt++;
        end
        @(negedge clk);
        m_data_addr = 32'h10;
        m_data_byteen = 4'h0;
        log_ready = 1'b0;
        #1;
        if (log_valid) vcnt++;
        chk("req034_occupancy_seen", 32'(vcnt), LOG ? 32'd4 : 32'd0);
        chk("req034_pre_rdata", m_data_rdata, 32'h5555_AAAA);
        #1;
        reset = 1'b1;
        #1;
        chk("req034_valid_at_once", {31'b0, log_valid}, 32'h0);
        chk("req034_rdata_reset", m_data_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step(32'h10, 4'h0, 32'h0, 32'h0, 1'b1, rd, hpc);
        chk("req034_after_reset", rd, 32'h0);
        step(32'h0, 4'h0, 32'h0, 32'h0, 1'b1, rd, hpc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3072, number of 32-bit words in the data array (byte range 0x0000..4*DEPTH_WORDS-1).
REQ-002 SHALL have parameter LOG_DEPTH, default 8, write-log FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port m_data_addr  input  32  byte address from the processor's memory stage.
REQ-006 SHALL have port m_data_byteen  input  4  byte-lane write enables; 0 means read-only cycle.
REQ-007 SHALL have port m_data_wdata  input  32  lane-aligned store data.
REQ-008 SHALL have port m_inst_addr  input  32  PC of the instruction issuing the access.
REQ-009 SHALL have port m_data_rdata  output  32  word read data, combinational.
REQ-010 SHALL have port err_oor  output  1  sticky out-of-range access flag.
REQ-011 SHALL have ports log_valid  output  1, log_ready  input  1  write-log handshake.
REQ-012 SHALL have ports log_pc  output  32, log_addr  output  32, log_byteen  output  4, log_wdata  output  32  head log entry.
REQ-013 SHALL have ports log_ovf  output  1 (sticky) and log_drops  output  8 (saturating dropped-entry count).

Function
REQ-014 Word index SHALL be m_data_addr[31:2]; addr[1:0] ignored; access in range iff index < DEPTH_WORDS.
REQ-015 In range: m_data_rdata SHALL equal the array word at index, combinationally, showing pre-write contents during a write cycle.
REQ-016 Out of range: m_data_rdata SHALL be 0.
REQ-017 On clk edge with in-range access, each lane i with byteen[i]=1 SHALL take wdata[8i+7:8i]; other lanes unchanged.
REQ-018 Out-of-range access with byteen != 0 SHALL modify no array word; any out-of-range access (read or write) SHALL set err_oor until reset.
REQ-019 Accepted write (in range, byteen != 0) SHALL push {m_inst_addr, {index,2'b00}, byteen, wdata} into the log FIFO on the same edge.
REQ-020 log_valid SHALL be 1 iff FIFO non-empty; log_* fields SHALL show the oldest entry; pop when log_valid && log_ready.
REQ-021 First entry SHALL be visible (log_valid=1) the cycle after its write edge; FIFO order strictly preserved.
REQ-022 Push while full without simultaneous pop: entry dropped, log_ovf set, log_drops incremented, saturating at 255.
REQ-023 Push while full with simultaneous pop: SHALL accept push, no drop, occupancy unchanged.
REQ-024 Pop while empty SHALL have no effect; read/write pointers wrap modulo LOG_DEPTH.

Reset
REQ-025 Reset SHALL immediately zero every array word, FIFO pointers/occupancy, err_oor, log_ovf, log_drops.
REQ-026 During reset: log_valid=0, log_* fields=0, m_data_rdata=0; writes arriving during reset ignored and not logged.
REQ-027 Reset asserted mid-stream SHALL discard all pending log entries without popping them.

Configuration
REQ-028 Macro DM_RESP_LOG_EN defined: write-log FIFO, log_ovf, log_drops implemented per REQ-019..024.
REQ-029 Macro DM_RESP_LOG_EN undefined: no FIFO storage; log_valid, log_* fields, log_ovf, log_drops tied 0; log_ready ignored; memory behaviour identical.

Verification
REQ-030 Write addr 0x10 byteen 4'b1111 wdata 0xDEADBEEF, then read 0x10 -> rdata 0xDEADBEEF; same-cycle rdata before edge = 0.
REQ-031 After REQ-030, write 0x12 byteen 4'b0100 wdata 0x00AA0000 -> read 0x10 = 0xDEAABEEF.
REQ-032 Write 0x3000 byteen 4'b1111 (DEPTH_WORDS=3072) -> err_oor=1, rdata 0, no log push, word 0 unchanged.
REQ-033 (LOG_EN) log_ready=0, 10 writes, pc 0x3000+4k -> log_ovf=1, log_drops=2; drain: 8 entries pc 0x3000..0x301C in order.
REQ-034 (LOG_EN) FIFO full, log_ready=1 plus write -> drops stay 0, occupancy 8; assert reset mid-drain -> log_valid=0 at once, array reads 0.
